// File: rtl/tl_mem_responder.sv
// tl_mem_responder: single-outstanding TileLink memory responder over a tagged 64-bit beat store
`ifndef ROCKET_PADDR_WIDTH
`define ROCKET_PADDR_WIDTH 32
`endif
`ifndef TagBits
`define TagBits 4
`endif
module tl_mem_responder #(
  parameter int ADDR_WIDTH = `ROCKET_PADDR_WIDTH,
  parameter int TAG_WIDTH  = `TagBits,
  parameter int CIS        = 7,
  parameter int MIS        = 2,
  parameter int CID        = 2,
  parameter int MEM_BLOCKS = 64
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  io_in_acquire_valid_i,
  output logic                  io_in_acquire_ready_o,
  input  logic [ADDR_WIDTH-7:0] io_in_acquire_bits_addr_block_i,
  input  logic [CIS-1:0]        io_in_acquire_bits_client_xact_id_i,
  input  logic [CID-1:0]        io_in_acquire_bits_client_id_i,
  input  logic [2:0]            io_in_acquire_bits_addr_beat_i,
  input  logic                  io_in_acquire_bits_is_builtin_type_i,
  input  logic [2:0]            io_in_acquire_bits_a_type_i,
  input  logic [12:0]           io_in_acquire_bits_union_i,
  input  logic [63:0]           io_in_acquire_bits_data_i,
  input  logic [TAG_WIDTH-1:0]  io_in_acquire_bits_tag_i,
  output logic                  io_in_grant_valid_o,
  input  logic                  io_in_grant_ready_i,
  output logic [2:0]            io_in_grant_bits_addr_beat_o,
  output logic [CIS-1:0]        io_in_grant_bits_client_xact_id_o,
  output logic [CID-1:0]        io_in_grant_bits_client_id_o,
  output logic [MIS-1:0]        io_in_grant_bits_manager_xact_id_o,
  output logic                  io_in_grant_bits_is_builtin_type_o,
  output logic [3:0]            io_in_grant_bits_g_type_o,
  output logic [63:0]           io_in_grant_bits_data_o,
  output logic [TAG_WIDTH-1:0]  io_in_grant_bits_tag_o,
  input  logic                  io_in_finish_valid_i,
  input  logic [MIS-1:0]        io_in_finish_bits_manager_xact_id_i,
  output logic                  io_in_finish_ready_o,
  output logic                  err_o
);
  localparam int BW    = $clog2(MEM_BLOCKS);
  localparam int DEPTH = MEM_BLOCKS * 8;

  typedef enum logic [1:0] {IDLE, WBURST, RBURST, RESP} state_e;

  state_e               state_q;
  logic [2:0]           beat_q;
  logic [BW-1:0]        blk_q;
  logic                 err_q;
  logic                 gv_q;
  logic [2:0]           g_beat_q;
  logic [CIS-1:0]       g_cxid_q;
  logic [CID-1:0]       g_cid_q;
  logic [3:0]           g_type_q;
  logic [63:0]          g_data_q;
  logic [TAG_WIDTH-1:0] g_tag_q;

  logic [63:0]          mem_data [DEPTH];
  logic [TAG_WIDTH-1:0] mem_tag  [DEPTH];

  logic [BW-1:0] blk_d;
  logic          is_get, is_getblk, is_put, is_putblk, is_pref, unsup;
  logic          wburst, acq_fire, grant_fire, wr_en;
  logic [7:0]    wr_mask;
  logic [BW+2:0] wr_idx, rd_idx;
  logic          unused_ok;

  assign blk_d = io_in_acquire_bits_addr_block_i[BW-1:0];

  always_comb begin
    is_get     = io_in_acquire_bits_is_builtin_type_i && io_in_acquire_bits_a_type_i == 3'd0;
    is_getblk  = io_in_acquire_bits_is_builtin_type_i && io_in_acquire_bits_a_type_i == 3'd1;
    is_put     = io_in_acquire_bits_is_builtin_type_i && io_in_acquire_bits_a_type_i == 3'd2;
    is_putblk  = io_in_acquire_bits_is_builtin_type_i && io_in_acquire_bits_a_type_i == 3'd3;
    is_pref    = io_in_acquire_bits_is_builtin_type_i && io_in_acquire_bits_a_type_i == 3'd5;
    unsup      = !(is_get || is_getblk || is_put || is_putblk || is_pref);
    wburst     = state_q == WBURST;
    acq_fire   = rstn_i && io_in_acquire_valid_i && (state_q == IDLE || wburst);
    grant_fire = gv_q && io_in_grant_ready_i;
    // Burst beats land at the internal counter; addr_beat only steers single-beat ops
    wr_en      = acq_fire && (wburst || is_put || is_putblk);
    wr_mask    = (wburst || is_putblk) ? 8'hFF : io_in_acquire_bits_union_i[8:1];
    wr_idx     = wburst ? {blk_q, beat_q}
                        : {blk_d, is_putblk ? beat_q : io_in_acquire_bits_addr_beat_i};
    // Read port prefetches the next beat so burst data stays registered
    rd_idx     = state_q == RBURST ? {blk_q, beat_q + 3'd1}
                                   : {blk_d, is_getblk ? 3'd0 : io_in_acquire_bits_addr_beat_i};
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++)
        if (wr_mask[b]) mem_data[wr_idx][8*b +: 8] <= io_in_acquire_bits_data_i[8*b +: 8];
      mem_tag[wr_idx] <= io_in_acquire_bits_tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      beat_q  <= 3'd0;
      err_q   <= 1'b0;
      gv_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (acq_fire) begin
          blk_q    <= blk_d;
          g_cxid_q <= io_in_acquire_bits_client_xact_id_i;
          g_cid_q  <= io_in_acquire_bits_client_id_i;
          g_beat_q <= is_get ? io_in_acquire_bits_addr_beat_i : 3'd0;
          g_type_q <= is_get ? 4'd4 : is_getblk ? 4'd5 : is_pref ? 4'd1 : 4'd3;
          g_data_q <= mem_data[rd_idx];
          g_tag_q  <= mem_tag[rd_idx];
          err_q    <= err_q | unsup;
          state_q  <= is_putblk ? WBURST : is_getblk ? RBURST : RESP;
          gv_q     <= !is_putblk;
          beat_q   <= is_putblk ? 3'd1 : 3'd0;
        end
        WBURST: if (acq_fire) begin
          beat_q <= beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            state_q <= RESP;
            gv_q    <= 1'b1;
          end
        end
        RBURST: if (grant_fire) begin
          beat_q   <= beat_q + 3'd1;
          g_beat_q <= beat_q + 3'd1;
          g_data_q <= mem_data[rd_idx];
          g_tag_q  <= mem_tag[rd_idx];
          if (beat_q == 3'd7) begin
            state_q <= IDLE;
            gv_q    <= 1'b0;
          end
        end
        RESP: if (grant_fire) begin
          state_q <= IDLE;
          gv_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_in_acquire_ready_o              = state_q == IDLE || wburst;
  assign io_in_grant_valid_o                = gv_q;
  assign io_in_grant_bits_addr_beat_o       = g_beat_q;
  assign io_in_grant_bits_client_xact_id_o  = g_cxid_q;
  assign io_in_grant_bits_client_id_o       = g_cid_q;
  assign io_in_grant_bits_manager_xact_id_o = '0;
  assign io_in_grant_bits_is_builtin_type_o = 1'b1;
  assign io_in_grant_bits_g_type_o          = g_type_q;
  assign io_in_grant_bits_data_o            = g_data_q;
  assign io_in_grant_bits_tag_o             = g_tag_q;
  assign io_in_finish_ready_o               = 1'b1;
  assign err_o                              = err_q;

  assign unused_ok = ^{io_in_acquire_bits_addr_block_i[ADDR_WIDTH-7:BW], io_in_acquire_bits_union_i[12:9],
                       io_in_acquire_bits_union_i[0], io_in_finish_valid_i, io_in_finish_bits_manager_xact_id_i};
endmodule
